idex_forward_stage: RTL and testbench
=====================================

Name: idex_forward_stage

Overview:
- ID/EX pipeline register of the MIPS core, plus the EX-stage forwarding (cortocircuito) selector.
- Captures decoded operands, register indices, immediate, PC+4 and control bits from ID each enabled cycle.
- Presents the captured values to EX and generates the 3-bit forwarding codes consumed by the ALU operand A/B muxes: 001 = EX/MEM, 010 = MEM/WB, 000 = ID/EX value.
- Supports pipeline bubbles (load-use stall or branch flush) and single-step hold from the debug unit.

Parameters:
BITS_SIZE, 32, width of data/immediate/PC paths
BITS_REGS, 5, register index width
BITS_CTRL, 10, control bundle width; bit0 = RegWrite, bit1 = MemRead, other bits opaque
BITS_CORTOCIRCUITO, 3, forwarding code width

Ports:
i_clk  in  1  clock, rising edge
i_reset  in  1  synchronous, active-high reset
i_step  in  1  pipeline advance enable from debug unit; 0 = hold all state
i_flush  in  1  load this cycle's entry as a bubble
i_reg1  in  BITS_SIZE  rs read data from ID
i_reg2  in  BITS_SIZE  rt read data from ID
i_imm  in  BITS_SIZE  sign/zero-extended immediate
i_pc4  in  BITS_SIZE  PC+4 of the instruction
i_rs  in  BITS_REGS  rs index
i_rt  in  BITS_REGS  rt index
i_rd  in  BITS_REGS  rd index
i_ctrl  in  BITS_CTRL  decoded control bundle
i_exmem_regwrite  in  1  RegWrite of the instruction in EX/MEM
i_exmem_rd  in  BITS_REGS  destination register in EX/MEM
i_memwb_regwrite  in  1  RegWrite of the instruction in MEM/WB
i_memwb_rd  in  BITS_REGS  destination register in MEM/WB
o_idex_register1  out  BITS_SIZE  registered rs data
o_idex_register2  out  BITS_SIZE  registered rt data
o_imm  out  BITS_SIZE  registered immediate
o_pc4  out  BITS_SIZE  registered PC+4
o_rs  out  BITS_REGS  registered rs index
o_rt  out  BITS_REGS  registered rt index
o_rd  out  BITS_REGS  registered rd index
o_ctrl  out  BITS_CTRL  registered control
o_valid  out  1  1 = entry holds a real instruction; 0 = bubble
o_corto_register_A  out  BITS_CORTOCIRCUITO  forwarding code for ALU operand A
o_corto_register_B  out  BITS_CORTOCIRCUITO  forwarding code for ALU operand B

Behaviour:
Register update, priority order, evaluated at each rising edge:
- i_reset = 1: all registered outputs go to 0, o_valid = 0. Applies even when i_step = 0.
- i_step = 0: hold all registers unchanged. i_flush is ignored.
- i_step = 1 and i_flush = 1: capture a bubble.
  - o_ctrl = 0, o_valid = 0.
  - o_rs, o_rt, o_rd = 0.
  - Data registers may capture inputs, but they are don't-care while o_valid = 0.
- i_step = 1 and i_flush = 0: capture all i_* fields, o_valid = 1.
- Latency: one cycle from ID inputs to outputs.
- A bubble has RegWrite = MemRead = 0, so it never causes a write downstream.

Forwarding logic (combinational):
- Inputs: registered o_rs/o_rt and the live EX/MEM and MEM/WB inputs. It re-evaluates while the stage is held.
- Operand A:
  - 001 if i_exmem_regwrite && i_exmem_rd != 0 && i_exmem_rd == o_rs;
  - else 010 if i_memwb_regwrite && i_memwb_rd != 0 && i_memwb_rd == o_rs;
  - else 000.
- Operand B: same rule using o_rt.
- EX/MEM takes priority over MEM/WB when both match (most recent result wins).
- Register 0 never forwards.
- Codes 011 and 1xx are never produced.
- After reset, o_rs = o_rt = 0, so both codes are 000.
- Reset mid-stall: reset wins. The next enabled capture proceeds normally.

Test Plan:
1. Reset: assert i_reset with i_step = 0 and all inputs nonzero -> next edge all outputs 0, o_valid = 0, both codes 000.
2. Capture: i_step = 1, i_rs = 3, i_reg1 = 0xDEADBEEF, i_ctrl = 0x3FF -> after one edge o_rs = 3, o_idex_register1 = 0xDEADBEEF, o_ctrl = 0x3FF, o_valid = 1.
3. Flush: hold scenario-2 inputs, pulse i_flush = 1 -> o_ctrl = 0, o_valid = 0, o_rs/o_rt/o_rd = 0, codes 000.
4. Forward priority: stage holds rs = 5, rt = 5; i_exmem_rd = 5 with regwrite = 1, i_memwb_rd = 5 with regwrite = 1 -> A = B = 001. Drop exmem regwrite -> 010. Drop memwb regwrite too -> 000.
5. $zero guard: o_rs = 0, i_exmem_rd = 0, regwrite = 1 -> code A = 000.
6. Step hold: i_step = 0 for 5 cycles while i_* change and i_flush = 1 -> outputs frozen. Forwarding codes still track changes on i_exmem_rd.

Source files
------------

// File: rtl/idex_forward_stage.sv
// idex_forward_stage: ID/EX pipeline register with bubble/hold control and
// the EX-stage forwarding selectors for ALU operands A and B.
module idex_forward_stage #(
    parameter int BITS_SIZE          = 32,
    parameter int BITS_REGS          = 5,
    parameter int BITS_CTRL          = 10,
    parameter int BITS_CORTOCIRCUITO = 3
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_step,
    input  logic                          i_flush,
    input  logic [BITS_SIZE-1:0]          i_reg1,
    input  logic [BITS_SIZE-1:0]          i_reg2,
    input  logic [BITS_SIZE-1:0]          i_imm,
    input  logic [BITS_SIZE-1:0]          i_pc4,
    input  logic [BITS_REGS-1:0]          i_rs,
    input  logic [BITS_REGS-1:0]          i_rt,
    input  logic [BITS_REGS-1:0]          i_rd,
    input  logic [BITS_CTRL-1:0]          i_ctrl,
    input  logic                          i_exmem_regwrite,
    input  logic [BITS_REGS-1:0]          i_exmem_rd,
    input  logic                          i_memwb_regwrite,
    input  logic [BITS_REGS-1:0]          i_memwb_rd,
    output logic [BITS_SIZE-1:0]          o_idex_register1,
    output logic [BITS_SIZE-1:0]          o_idex_register2,
    output logic [BITS_SIZE-1:0]          o_imm,
    output logic [BITS_SIZE-1:0]          o_pc4,
    output logic [BITS_REGS-1:0]          o_rs,
    output logic [BITS_REGS-1:0]          o_rt,
    output logic [BITS_REGS-1:0]          o_rd,
    output logic [BITS_CTRL-1:0]          o_ctrl,
    output logic                          o_valid,
    output logic [BITS_CORTOCIRCUITO-1:0] o_corto_register_A,
    output logic [BITS_CORTOCIRCUITO-1:0] o_corto_register_B
);
    localparam logic [BITS_CORTOCIRCUITO-1:0] FWD_EXMEM = BITS_CORTOCIRCUITO'(1);
    localparam logic [BITS_CORTOCIRCUITO-1:0] FWD_MEMWB = BITS_CORTOCIRCUITO'(2);
    localparam logic [BITS_CORTOCIRCUITO-1:0] FWD_NONE  = '0;

    logic [BITS_SIZE-1:0] reg1_q, reg1_d, reg2_q, reg2_d, imm_q, imm_d, pc4_q, pc4_d;
    logic [BITS_REGS-1:0] rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
    logic [BITS_CTRL-1:0] ctrl_q, ctrl_d;
    logic                 valid_q, valid_d;

    always_comb begin
        reg1_d  = i_step ? i_reg1 : reg1_q;
        reg2_d  = i_step ? i_reg2 : reg2_q;
        imm_d   = i_step ? i_imm : imm_q;
        pc4_d   = i_step ? i_pc4 : pc4_q;
        rs_d    = i_step ? (i_flush ? '0 : i_rs) : rs_q;
        rt_d    = i_step ? (i_flush ? '0 : i_rt) : rt_q;
        rd_d    = i_step ? (i_flush ? '0 : i_rd) : rd_q;
        ctrl_d  = i_step ? (i_flush ? '0 : i_ctrl) : ctrl_q;
        valid_d = i_step ? !i_flush : valid_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            reg1_q  <= '0;
            reg2_q  <= '0;
            imm_q   <= '0;
            pc4_q   <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
            ctrl_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            reg1_q  <= reg1_d;
            reg2_q  <= reg2_d;
            imm_q   <= imm_d;
            pc4_q   <= pc4_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            rd_q    <= rd_d;
            ctrl_q  <= ctrl_d;
            valid_q <= valid_d;
        end
    end

    // EX/MEM is checked first so the most recent producer wins; $zero never forwards.
    logic exmem_live, memwb_live;
    assign exmem_live = i_exmem_regwrite && (i_exmem_rd != '0);
    assign memwb_live = i_memwb_regwrite && (i_memwb_rd != '0);

    always_comb begin
        o_corto_register_A = (exmem_live && i_exmem_rd == rs_q) ? FWD_EXMEM :
                             (memwb_live && i_memwb_rd == rs_q) ? FWD_MEMWB : FWD_NONE;
        o_corto_register_B = (exmem_live && i_exmem_rd == rt_q) ? FWD_EXMEM :
                             (memwb_live && i_memwb_rd == rt_q) ? FWD_MEMWB : FWD_NONE;
    end

    assign o_idex_register1 = reg1_q;
    assign o_idex_register2 = reg2_q;
    assign o_imm            = imm_q;
    assign o_pc4            = pc4_q;
    assign o_rs             = rs_q;
    assign o_rt             = rt_q;
    assign o_rd             = rd_q;
    assign o_ctrl           = ctrl_q;
    assign o_valid          = valid_q;
endmodule

// File: tb/tb_idex_forward_stage.sv
// tb_idex_forward_stage: directed plus randomized checks of the ID/EX register
// and forwarding selector against a behavioural model.
module tb_idex_forward_stage;
    logic        i_clk = 1'b0;
    logic        i_reset, i_step, i_flush;
    logic [31:0] i_reg1, i_reg2, i_imm, i_pc4;
    logic [4:0]  i_rs, i_rt, i_rd, i_exmem_rd, i_memwb_rd;
    logic [9:0]  i_ctrl;
    logic        i_exmem_regwrite, i_memwb_regwrite;
    logic [31:0] o_idex_register1, o_idex_register2, o_imm, o_pc4;
    logic [4:0]  o_rs, o_rt, o_rd;
    logic [9:0]  o_ctrl;
    logic        o_valid;
    logic [2:0]  o_corto_register_A, o_corto_register_B;

    int errors = 0;
    int checks = 0;

    logic [31:0] m_reg1, m_reg2, m_imm, m_pc4;
    logic [4:0]  m_rs, m_rt, m_rd;
    logic [9:0]  m_ctrl;
    logic        m_valid;

    idex_forward_stage dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_step(i_step), .i_flush(i_flush),
        .i_reg1(i_reg1), .i_reg2(i_reg2), .i_imm(i_imm), .i_pc4(i_pc4),
        .i_rs(i_rs), .i_rt(i_rt), .i_rd(i_rd), .i_ctrl(i_ctrl),
        .i_exmem_regwrite(i_exmem_regwrite), .i_exmem_rd(i_exmem_rd),
        .i_memwb_regwrite(i_memwb_regwrite), .i_memwb_rd(i_memwb_rd),
        .o_idex_register1(o_idex_register1), .o_idex_register2(o_idex_register2),
        .o_imm(o_imm), .o_pc4(o_pc4), .o_rs(o_rs), .o_rt(o_rt), .o_rd(o_rd),
        .o_ctrl(o_ctrl), .o_valid(o_valid),
        .o_corto_register_A(o_corto_register_A), .o_corto_register_B(o_corto_register_B)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Most recent writer wins; register 0 is hardwired and never forwarded.
    function automatic logic [31:0] fwd(input logic [4:0] src);
        if (src == 0) return 0;
        if (i_exmem_regwrite && i_exmem_rd == src) return 1;
        if (i_memwb_regwrite && i_memwb_rd == src) return 2;
        return 0;
    endfunction

    task automatic check_fwd(input string tag);
        chk({tag, ".fwdA"}, {29'd0, o_corto_register_A}, fwd(m_rs));
        chk({tag, ".fwdB"}, {29'd0, o_corto_register_B}, fwd(m_rt));
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid"}, {31'd0, o_valid}, {31'd0, m_valid});
        chk({tag, ".ctrl"}, {22'd0, o_ctrl}, {22'd0, m_ctrl});
        chk({tag, ".rs"}, {27'd0, o_rs}, {27'd0, m_rs});
        chk({tag, ".rt"}, {27'd0, o_rt}, {27'd0, m_rt});
        chk({tag, ".rd"}, {27'd0, o_rd}, {27'd0, m_rd});
        if (m_valid || i_reset === 1'b1) begin
            chk({tag, ".reg1"}, o_idex_register1, m_reg1);
            chk({tag, ".reg2"}, o_idex_register2, m_reg2);
            chk({tag, ".imm"}, o_imm, m_imm);
            chk({tag, ".pc4"}, o_pc4, m_pc4);
        end
        check_fwd(tag);
    endtask

    // Apply one rising edge and advance the model from the inputs present at that edge.
    task automatic clock_edge();
        if (i_reset) begin
            {m_reg1, m_reg2, m_imm, m_pc4} = '0;
            {m_rs, m_rt, m_rd, m_ctrl, m_valid} = '0;
        end else if (i_step && i_flush) begin
            {m_reg1, m_reg2, m_imm, m_pc4} = {i_reg1, i_reg2, i_imm, i_pc4};
            {m_rs, m_rt, m_rd, m_ctrl, m_valid} = '0;
        end else if (i_step) begin
            {m_reg1, m_reg2, m_imm, m_pc4} = {i_reg1, i_reg2, i_imm, i_pc4};
            {m_rs, m_rt, m_rd, m_ctrl} = {i_rs, i_rt, i_rd, i_ctrl};
            m_valid = 1'b1;
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic rand_id();
        i_reg1 = $urandom; i_reg2 = $urandom; i_imm = $urandom; i_pc4 = $urandom;
        i_rs = 5'($urandom_range(0, 7)); i_rt = 5'($urandom_range(0, 7));
        i_rd = 5'($urandom); i_ctrl = 10'($urandom);
    endtask

    task automatic rand_fwd();
        i_exmem_regwrite = 1'($urandom); i_memwb_regwrite = 1'($urandom);
        i_exmem_rd = 5'($urandom_range(0, 7)); i_memwb_rd = 5'($urandom_range(0, 7));
    endtask

    initial begin
        i_reset = 1'b1; i_step = 1'b0; i_flush = 1'b1;
        i_reg1 = 32'h1111_1111; i_reg2 = 32'h2222_2222; i_imm = 32'h3333_3333; i_pc4 = 32'h4444_4444;
        i_rs = 5'd7; i_rt = 5'd9; i_rd = 5'd11; i_ctrl = 10'h155;
        i_exmem_regwrite = 1'b1; i_exmem_rd = 5'd3; i_memwb_regwrite = 1'b1; i_memwb_rd = 5'd4;
        @(negedge i_clk);
        clock_edge();
        check_all("reset");
        chk("reset.codeA_zero", {29'd0, o_corto_register_A}, 32'd0);

        i_reset = 1'b0; i_step = 1'b1; i_flush = 1'b0;
        i_rs = 5'd3; i_reg1 = 32'hDEAD_BEEF; i_ctrl = 10'h3FF;
        clock_edge();
        check_all("capture");
        chk("capture.reg1_lit", o_idex_register1, 32'hDEAD_BEEF);

        i_flush = 1'b1;
        clock_edge();
        check_all("flush");

        i_flush = 1'b0; i_rs = 5'd5; i_rt = 5'd5;
        clock_edge();
        i_step = 1'b0;
        i_exmem_rd = 5'd5; i_memwb_rd = 5'd5; i_exmem_regwrite = 1'b1; i_memwb_regwrite = 1'b1;
        #1 check_fwd("prio_both");
        chk("prio_both.lit", {29'd0, o_corto_register_A}, 32'd1);
        i_exmem_regwrite = 1'b0;
        #1 check_fwd("prio_memwb");
        chk("prio_memwb.lit", {29'd0, o_corto_register_B}, 32'd2);
        i_memwb_regwrite = 1'b0;
        #1 check_fwd("prio_none");

        i_step = 1'b1; i_rs = 5'd0; i_rt = 5'd0;
        clock_edge();
        i_exmem_rd = 5'd0; i_exmem_regwrite = 1'b1; i_memwb_rd = 5'd0; i_memwb_regwrite = 1'b1;
        #1 check_fwd("zero_guard");
        chk("zero_guard.lit", {29'd0, o_corto_register_A}, 32'd0);

        i_rs = 5'd6; i_rt = 5'd2; i_flush = 1'b0;
        clock_edge();
        i_step = 1'b0; i_flush = 1'b1;
        for (int k = 0; k < 5; k++) begin
            rand_id();
            rand_fwd();
            clock_edge();
            check_all("hold");
            i_exmem_regwrite = 1'b1; i_exmem_rd = 5'(k + 1);
            #1 check_fwd("hold_track");
        end

        i_reset = 1'b1;
        clock_edge();
        check_all("reset_mid_stall");
        i_reset = 1'b0; i_step = 1'b1; i_flush = 1'b0; rand_id();
        clock_edge();
        check_all("after_reset");

        for (int n = 0; n < 400; n++) begin
            i_reset = ($urandom_range(0, 39) == 0);
            i_step = ($urandom_range(0, 3) != 0);
            i_flush = ($urandom_range(0, 4) == 0);
            rand_id();
            rand_fwd();
            clock_edge();
            check_all("rand");
            rand_fwd();
            #1 check_fwd("rand_fwd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
